// File: rtl/dcache_pkg.sv
// Shared types and helpers for the N-way write-back data cache controller.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

  // Field widths for the default geometry (28-bit word address, 1024 sets, 8-word lines).
  localparam int unsigned DEF_OFFSET_W = clog2(256 / 32);
  localparam int unsigned DEF_INDEX_W  = clog2(1024);
  localparam int unsigned DEF_TAG_W    = 28 - DEF_INDEX_W - DEF_OFFSET_W;

endpackage

// File: rtl/cache_way_mem.sv
// One cache way: tag/valid/dirty/line arrays, synchronous write, asynchronous read.
module cache_way_mem #(
  parameter int unsigned NUM_SETS   = 1024,
  parameter int unsigned INDEX_W    = 10,
  parameter int unsigned TAG_W      = 15,
  parameter int unsigned BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    index,
  input  logic [TAG_W-1:0]      tag_in,
  input  logic [BLOCK_SIZE-1:0] line_in,
  input  logic                  fill_we,
  input  logic                  hit_we,
  input  logic                  clean_we,
  output logic [TAG_W-1:0]      tag_out,
  output logic [BLOCK_SIZE-1:0] line_out,
  output logic                  valid_out,
  output logic                  dirty_out
);

  logic [TAG_W-1:0]      tags  [NUM_SETS];
  logic [BLOCK_SIZE-1:0] lines [NUM_SETS];
  logic [NUM_SETS-1:0]   valid;
  logic [NUM_SETS-1:0]   dirty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (hit_we) begin
      dirty[index] <= 1'b1;
    end else if (clean_we) begin
      dirty[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tags[index]  <= tag_in;
      lines[index] <= line_in;
    end else if (hit_we) begin
      lines[index] <= line_in;
    end
  end

  assign tag_out   = tags[index];
  assign line_out  = lines[index];
  assign valid_out = valid[index];
  assign dirty_out = dirty[index];

endmodule

// File: rtl/dcache_ctrl_nway.sv
// N-way set-associative write-back data cache controller with LRU, flush and IO bypass.
module dcache_ctrl_nway
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned NUM_SETS   = 1024,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 256,
  parameter int unsigned IO_BIT     = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_rw,
  input  logic                  cpu_valid,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  flush_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  output logic                  mem_rw,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_rw,
  output logic                  io_valid,
  input  logic [DATA_WIDTH-1:0] io_rdata,
  input  logic                  io_ready
);

  localparam int unsigned WORDS = BLOCK_SIZE / DATA_WIDTH;
  localparam int unsigned OFF_W = clog2(WORDS);
  localparam int unsigned IDX_W = clog2(NUM_SETS);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1;

  state_t state, next_state;
  logic   pending;
  logic [WAY_W-1:0] victim, miss_way, hit_way, scan_way, lru_way;
  logic [IDX_W-1:0] scan_set, way_idx;
  logic [WAY_W:0]   hit_cnt;
  logic             hit, found, scan_adv, last_entry, lru_en;
  logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [OFF_W-1:0]      req_off;
  logic [TAG_W-1:0]      way_tag  [NUM_WAYS];
  logic [BLOCK_SIZE-1:0] way_line [NUM_WAYS];
  logic [NUM_WAYS-1:0]   way_valid, way_dirty, fill_we, hit_we, clean_we;
  logic [BLOCK_SIZE-1:0] hit_line, merged_line, line_in;
  logic [DATA_WIDTH-1:0] rd_word;

  assign req_tag = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = cpu_addr[OFF_W +: IDX_W];
  assign req_off = cpu_addr[OFF_W-1:0];
  assign way_idx = (state == FLUSH_SCAN || state == FLUSH_WB) ? scan_set : req_idx;
  assign line_in = (state == ALLOCATE) ? mem_rdata : merged_line;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    cache_way_mem #(
      .NUM_SETS(NUM_SETS), .INDEX_W(IDX_W), .TAG_W(TAG_W), .BLOCK_SIZE(BLOCK_SIZE)
    ) u_way (
      .clk(clk), .rst(rst), .index(way_idx), .tag_in(req_tag), .line_in(line_in),
      .fill_we(fill_we[g]), .hit_we(hit_we[g]), .clean_we(clean_we[g]),
      .tag_out(way_tag[g]), .line_out(way_line[g]),
      .valid_out(way_valid[g]), .dirty_out(way_dirty[g])
    );
  end

  always_comb begin
    hit_cnt  = '0;
    hit_way  = '0;
    found    = 1'b0;
    miss_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (way_valid[WAY_W'(w)] && way_tag[WAY_W'(w)] == req_tag) begin
        hit_cnt = hit_cnt + 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found && !way_valid[WAY_W'(w)]) begin
        miss_way = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found)
      for (int unsigned w = 0; w < NUM_WAYS; w++)
        if (age[req_idx][WAY_W'(w)] == WAY_W'(NUM_WAYS - 1)) miss_way = WAY_W'(w);
  end

  assign hit = (hit_cnt == 1);

  always_comb begin
    hit_line    = way_line[hit_way];
    rd_word     = hit_line[req_off*DATA_WIDTH +: DATA_WIDTH];
    merged_line = hit_line;
    merged_line[req_off*DATA_WIDTH +: DATA_WIDTH] = cpu_wdata;
  end

  assign last_entry = (scan_set == IDX_W'(NUM_SETS - 1)) && (scan_way == WAY_W'(NUM_WAYS - 1));
  assign lru_en     = (state == COMPARE && hit) || (state == ALLOCATE && mem_ready);
  assign lru_way    = (state == ALLOCATE) ? victim : hit_way;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      victim   <= '0;
      scan_set <= '0;
      scan_way <= '0;
    end else begin
      if (state == IDLE && (flush || pending)) pending <= 1'b0;
      else if (flush)                          pending <= 1'b1;
      if (state == COMPARE && !hit) victim <= miss_way;
      if (state == IDLE) begin
        scan_set <= '0;
        scan_way <= '0;
      end else if (scan_adv) begin
        if (scan_way == WAY_W'(NUM_WAYS - 1)) begin
          scan_way <= '0;
          scan_set <= scan_set + 1'b1;
        end else begin
          scan_way <= scan_way + 1'b1;
        end
      end
    end
  end

  // Move-to-front: only ways younger than the accessed one age, keeping a permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++)
        for (int unsigned w = 0; w < NUM_WAYS; w++)
          age[IDX_W'(s)][WAY_W'(w)] <= WAY_W'(w);
    end else if (lru_en) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == lru_way)
          age[req_idx][WAY_W'(w)] <= '0;
        else if (age[req_idx][WAY_W'(w)] < age[req_idx][lru_way])
          age[req_idx][WAY_W'(w)] <= age[req_idx][WAY_W'(w)] + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    cpu_rdata  = '0;
    cpu_ready  = 1'b0;
    flush_done = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rw     = 1'b0;
    mem_valid  = 1'b0;
    io_addr    = '0;
    io_wdata   = '0;
    io_rw      = 1'b0;
    io_valid   = 1'b0;
    fill_we    = '0;
    hit_we     = '0;
    clean_we   = '0;
    scan_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (flush || pending) begin
          next_state = FLUSH_SCAN;
        end else if (cpu_addr[IO_BIT]) begin
          if (!rst) begin
            io_addr   = cpu_addr;
            io_wdata  = cpu_wdata;
            io_rw     = cpu_rw;
            io_valid  = cpu_valid;
            cpu_rdata = io_rdata;
            cpu_ready = io_ready;
          end
        end else if (cpu_valid) begin
          next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          next_state = IDLE;
          if (cpu_rw) hit_we[hit_way] = 1'b1;
          else        cpu_rdata = rd_word;
        end else if (way_valid[miss_way] && way_dirty[miss_way]) begin
          next_state = WRITE_BACK;
        end else begin
          next_state = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {way_tag[victim], req_idx, {OFF_W{1'b0}}};
        mem_wdata = way_line[victim];
        if (mem_ready) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_valid = 1'b1;
        mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ready) begin
          fill_we[victim] = 1'b1;
          next_state      = COMPARE;
        end
      end
      FLUSH_SCAN: begin
        if (way_valid[scan_way] && way_dirty[scan_way]) begin
          next_state = FLUSH_WB;
        end else begin
          scan_adv = 1'b1;
          if (last_entry) begin
            flush_done = 1'b1;
            next_state = IDLE;
          end
        end
      end
      FLUSH_WB: begin
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {way_tag[scan_way], scan_set, {OFF_W{1'b0}}};
        mem_wdata = way_line[scan_way];
        if (mem_ready) begin
          clean_we[scan_way] = 1'b1;
          scan_adv           = 1'b1;
          if (last_entry) begin
            flush_done = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = FLUSH_SCAN;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Directed self-checking bench for dcache_ctrl_nway with a behavioural line memory.
module tb_dcache_ctrl_nway;

  logic         clk, rst;
  logic [27:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_rw, cpu_valid, flush, cpu_ready, flush_done;
  logic [27:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_rw, mem_valid, mem_ready;
  logic [27:0]  io_addr;
  logic [31:0]  io_wdata, io_rdata;
  logic         io_rw, io_valid, io_ready;

  dcache_ctrl_nway dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw),
    .cpu_valid(cpu_valid), .flush(flush), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush_done(flush_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rw(mem_rw), .mem_valid(mem_valid), .mem_ready(mem_ready), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rw(io_rw), .io_valid(io_valid), .io_rdata(io_rdata),
    .io_ready(io_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory: unwritten lines read as word i = {4'h5, line_addr} + i.
  logic [255:0] store [logic [27:0]];
  int           wb_cnt = 0, fill_cnt = 0, mv_cycles = 0, wdata_leak = 0;
  logic [27:0]  last_wb_addr, last_fill_addr;
  logic [255:0] last_wb_data;
  bit           mem_hold = 0;

  function automatic logic [255:0] pattern(input logic [27:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {4'h5, a} + 32'(i);
    return l;
  endfunction

  function automatic logic [31:0] pword(input logic [27:0] a);
    return {4'h5, a};
  endfunction

  always @(negedge clk) begin
    mem_ready = mem_valid && !mem_hold;
    if (mem_valid) mv_cycles++;
    mem_rdata = store.exists(mem_addr) ? store[mem_addr] : pattern(mem_addr);
    if (mem_ready) begin
      if (mem_rw) begin
        wb_cnt++;
        last_wb_addr = mem_addr;
        last_wb_data = mem_wdata;
        store[mem_addr] = mem_wdata;
      end else begin
        fill_cnt++;
        last_fill_addr = mem_addr;
        if (mem_wdata != '0) wdata_leak++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request completes.
  task automatic acc(input string tag, input logic [27:0] a, input logic rw, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd, input int exp_wb);
    int lat, wb0;
    logic done;
    logic [31:0] rd;
    wb0 = wb_cnt; lat = 0; done = 1'b0; rd = '0;
    cpu_addr = a; cpu_rw = rw; cpu_wdata = wd; cpu_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_ready) begin done = 1'b1; rd = cpu_rdata; end
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_rw = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, lat, exp_lat);
    if (!rw) check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_wb"}, wb_cnt - wb0, exp_wb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] l;
    int n, wb0, mv0, f0;
    logic done;
    l = pattern(28'h120);
    l[96 +: 32] = 32'hDEADBEEF;
    store[28'h120] = l;

    rst = 1'b1; flush = 1'b0; cpu_rw = 1'b0; cpu_wdata = '0;
    cpu_addr = 28'h8000004; cpu_valid = 1'b1;
    io_rdata = 32'hCAFE0001; io_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {cpu_ready, flush_done, mem_valid, mem_rw, io_valid, io_rw}, '0);
    check("rst_data", {mem_addr, io_addr, io_wdata, cpu_rdata}, '0);
    check("rst_wdata", mem_wdata, '0);
    cpu_valid = 1'b0; io_ready = 1'b0; cpu_addr = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Read miss then re-read hit
    f0 = fill_cnt;
    acc("miss123", 28'h0000123, 1'b0, '0, 4, 32'hDEADBEEF, 0);
    check("miss123_fill_addr", last_fill_addr, 28'h0000120);
    check("miss123_fills", fill_cnt - f0, 1);
    f0 = fill_cnt;
    acc("hit123", 28'h0000123, 1'b0, '0, 2, 32'hDEADBEEF, 0);
    check("hit123_fills", fill_cnt - f0, 0);

    // Four dirty lines in set 0, then a fifth tag evicts the LRU one (tag 1)
    for (int t = 1; t <= 4; t++)
      acc("wr_set0", 28'(t) << 13, 1'b1, 32'h11111111, 4, '0, 0);
    acc("evict_a000", 28'h000A000, 1'b0, '0, 5, pword(28'h000A000), 1);
    check("evict_wb_addr", last_wb_addr, 28'h0002000);
    check("evict_wb_w0", last_wb_data[31:0], 32'h11111111);
    check("evict_wb_w1", last_wb_data[63:32], 32'h50002001);
    acc("refetch_2000", 28'h0002000, 1'b0, '0, 5, 32'h11111111, 1);
    check("refetch_wb_addr", last_wb_addr, 28'h0004000);

    // LRU in set 5: A..D fill, touch A, E evicts B
    for (int t = 1; t <= 4; t++)
      acc("fill_set5", (28'(t) << 13) | 28'h28, 1'b0, '0, 4, pword((28'(t) << 13) | 28'h28), 0);
    acc("lru_hit_a", 28'h0002028, 1'b0, '0, 2, pword(28'h0002028), 0);
    acc("lru_miss_e", 28'h000A028, 1'b0, '0, 4, pword(28'h000A028), 0);
    acc("lru_keep_a", 28'h0002028, 1'b0, '0, 2, pword(28'h0002028), 0);
    acc("lru_keep_c", 28'h0006028, 1'b0, '0, 2, pword(28'h0006028), 0);
    acc("lru_keep_d", 28'h0008028, 1'b0, '0, 2, pword(28'h0008028), 0);
    acc("lru_gone_b", 28'h0004028, 1'b0, '0, 4, pword(28'h0004028), 0);

    // Flush with exactly two dirty lines (set 0, tags 3 and 4)
    wb0 = wb_cnt; mv0 = mv_cycles; n = 0; done = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      n++;
      if (flush_done) done = 1'b1;
    end
    check("flush_done", done, 1'b1);
    check("flush_wb", wb_cnt - wb0, 2);
    check("flush_mv_cycles", mv_cycles - mv0, 2);
    check("flush_cycles", n, 4098);
    @(negedge clk);
    check("flush_done_pulse", flush_done, 1'b0);
    @(posedge clk); #1;
    acc("flushed_6000", 28'h0006000, 1'b0, '0, 2, 32'h11111111, 0);
    acc("flushed_8000", 28'h0008000, 1'b0, '0, 2, 32'h11111111, 0);
    for (int t = 6; t <= 9; t++)
      acc("clean_evict", 28'(t) << 13, 1'b0, '0, 4, pword(28'(t) << 13), 0);

    // Flush raised mid-request is held pending and runs afterwards
    wb0 = wb_cnt; done = 1'b0;
    cpu_addr = 28'h0000008; cpu_rw = 1'b0; cpu_valid = 1'b1;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cpu_ready) begin done = 1'b1; check("pend_rdata", cpu_rdata, pword(28'h0000008)); end
    end
    check("pend_req_done", done, 1'b1);
    @(posedge clk); #1 cpu_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      if (flush_done) done = 1'b1;
    end
    check("pend_flush_done", done, 1'b1);
    check("pend_flush_wb", wb_cnt - wb0, 0);
    @(posedge clk); #1;

    // IO bypass
    cpu_addr = 28'h8000004; cpu_rw = 1'b0; cpu_valid = 1'b1;
    io_rdata = 32'hCAFE0001; io_ready = 1'b0;
    @(negedge clk);
    check("io_req", {io_valid, io_rw, io_addr, cpu_ready, mem_valid}, {1'b1, 1'b0, 28'h8000004, 1'b0, 1'b0});
    #1 io_ready = 1'b1;
    #1 check("io_resp", {cpu_ready, cpu_rdata}, {1'b1, 32'hCAFE0001});
    @(posedge clk); #1;
    cpu_addr = 28'h8000010; cpu_rw = 1'b1; cpu_wdata = 32'h12345678;
    #1 check("io_write", {io_rw, io_wdata, io_addr, cpu_ready}, {1'b1, 32'h12345678, 28'h8000010, 1'b1});
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_rw = 1'b0; io_ready = 1'b0;
    @(negedge clk);
    check("io_idle", {io_valid, mem_valid}, '0);
    @(posedge clk); #1;
    acc("after_io_hit", 28'h0000008, 1'b0, '0, 2, pword(28'h0000008), 0);

    // Reset during ALLOCATE
    mem_hold = 1; done = 1'b0;
    cpu_addr = 28'h0000777; cpu_rw = 1'b0; cpu_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (mem_valid) done = 1'b1;
    end
    check("alloc_reached", done, 1'b1);
    #1 rst = 1'b1;
    #1 check("rst_mid_alloc", {mem_valid, cpu_ready, flush_done}, '0);
    cpu_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; mem_hold = 0;
    @(posedge clk); #1;
    acc("post_rst_777", 28'h0000777, 1'b0, '0, 4, 32'h50000777, 0);
    acc("post_rst_123", 28'h0000123, 1'b0, '0, 4, 32'hDEADBEEF, 0);

    check("fill_wdata_zero", wdata_leak, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
